// File: rtl/lsu_bus_master.sv
// MEM-stage load/store bus initiator: issues one word-aligned req/ack transaction per memory op,
// stalls the pipeline until the response (or a timeout) and reports address/bus errors.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemAccess_In,
  input  logic [5:0]  Op_In,
  input  logic [31:0] Addr_In,
  input  logic [31:0] D_In,
  output logic        Stall_Out,
  output logic [31:0] D_Out,
  output logic        AdEL_Out,
  output logic        AdES_Out,
  output logic        Bus_Err_Out,
  output logic        Bus_Req_Out,
  output logic        Bus_We_Out,
  output logic [3:0]  Bus_Be_Out,
  output logic [31:0] Bus_Addr_Out,
  output logic [31:0] Bus_WData_Out,
  input  logic        Bus_Ack_In,
  input  logic [31:0] Bus_RData_In
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            we_q, sign_q;
  size_e           size_q;
  logic [1:0]      lo_q;
  logic [31:0]     d_q;
  logic            adel_q, ades_q, err_q, req_q;
  logic [3:0]      be_q;
  logic [31:0]     addr_q, wdata_q;

  logic        is_load, is_store, is_signed, misaligned, start;
  size_e       size;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, rshift, load_ext;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SzWord;
    case (Op_In)
      6'b100011: begin is_load  = 1'b1; size = SzWord; end
      6'b100000: begin is_load  = 1'b1; size = SzByte; is_signed = 1'b1; end
      6'b100100: begin is_load  = 1'b1; size = SzByte; end
      6'b100001: begin is_load  = 1'b1; size = SzHalf; is_signed = 1'b1; end
      6'b100101: begin is_load  = 1'b1; size = SzHalf; end
      6'b101011: begin is_store = 1'b1; size = SzWord; end
      6'b101000: begin is_store = 1'b1; size = SzByte; end
      6'b101001: begin is_store = 1'b1; size = SzHalf; end
      default: ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = D_In;
    case (size)
      SzWord: misaligned = (Addr_In[1:0] != 2'b00);
      SzHalf: begin
        misaligned = Addr_In[0];
        be_new     = Addr_In[1] ? 4'b1100 : 4'b0011;
        wdata_new  = {2{D_In[15:0]}};
      end
      default: begin
        be_new    = 4'b0001 << Addr_In[1:0];
        wdata_new = {4{D_In[7:0]}};
      end
    endcase
  end

  assign start = (state_q == StIdle) && MemAccess_In && (is_load || is_store);

  // Load extraction works from the latched low address bits, not the live Addr_In.
  assign rshift = Bus_RData_In >> {lo_q, 3'b000};
  always_comb begin
    case (size_q)
      SzByte:  load_ext = {{24{sign_q & rshift[7]}}, rshift[7:0]};
      SzHalf:  load_ext = {{16{sign_q & rshift[15]}}, rshift[15:0]};
      default: load_ext = Bus_RData_In;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = misaligned ? StDone : StReq;
      StReq:  if (Bus_Ack_In || cnt_q == CntLast) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= SzWord;
      lo_q    <= 2'b00;
      d_q     <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == StReq);
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (misaligned) begin
              adel_q <= is_load;
              ades_q <= is_store;
            end else begin
              we_q    <= is_store;
              sign_q  <= is_signed;
              size_q  <= size;
              lo_q    <= Addr_In[1:0];
              be_q    <= be_new;
              addr_q  <= {Addr_In[31:2], 2'b00};
              wdata_q <= wdata_new;
              cnt_q   <= '0;
            end
          end
        end
        StReq: begin
          if (Bus_Ack_In) begin
            if (!we_q) d_q <= load_ext;
          end else if (cnt_q == CntLast) begin
            err_q <= 1'b1;
            d_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Stall_Out     = !Reset && (start || state_q == StReq);
  assign D_Out         = d_q;
  assign AdEL_Out      = adel_q;
  assign AdES_Out      = ades_q;
  assign Bus_Err_Out   = err_q;
  assign Bus_Req_Out   = req_q;
  assign Bus_We_Out    = (state_q == StReq) && we_q;
  assign Bus_Be_Out    = be_q;
  assign Bus_Addr_Out  = addr_q;
  assign Bus_WData_Out = wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: expected completions are queued at issue and checked
// when the DONE cycle appears.
module tb_lsu_bus_master;

  localparam int unsigned TO = 4;

  localparam logic [5:0] OpLw = 6'b100011, OpLb = 6'b100000, OpLbu = 6'b100100;
  localparam logic [5:0] OpLh = 6'b100001, OpLhu = 6'b100101;
  localparam logic [5:0] OpSw = 6'b101011, OpSb = 6'b101000, OpSh = 6'b101001;

  logic        Clk, Reset, MemAccess_In;
  logic [5:0]  Op_In;
  logic [31:0] Addr_In, D_In;
  logic        Stall_Out;
  logic [31:0] D_Out;
  logic        AdEL_Out, AdES_Out, Bus_Err_Out, Bus_Req_Out, Bus_We_Out;
  logic [3:0]  Bus_Be_Out;
  logic [31:0] Bus_Addr_Out, Bus_WData_Out;
  logic        Bus_Ack_In;
  logic [31:0] Bus_RData_In;

  lsu_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .MemAccess_In(MemAccess_In), .Op_In(Op_In), .Addr_In(Addr_In),
    .D_In(D_In), .Stall_Out(Stall_Out), .D_Out(D_Out), .AdEL_Out(AdEL_Out),
    .AdES_Out(AdES_Out), .Bus_Err_Out(Bus_Err_Out), .Bus_Req_Out(Bus_Req_Out),
    .Bus_We_Out(Bus_We_Out), .Bus_Be_Out(Bus_Be_Out), .Bus_Addr_Out(Bus_Addr_Out),
    .Bus_WData_Out(Bus_WData_Out), .Bus_Ack_In(Bus_Ack_In), .Bus_RData_In(Bus_RData_In)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] d;
    logic        adel, ades, err;
    int          stall, reqs;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_d = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_st(input logic [5:0] op);
    return (op == OpSw) || (op == OpSb) || (op == OpSh);
  endfunction

  function automatic logic misal(input logic [5:0] op, input logic [31:0] a);
    if (op == OpLw || op == OpSw) return a[1:0] != 2'b00;
    if (op == OpLh || op == OpLhu || op == OpSh) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [5:0] op, input logic [31:0] a);
    if (op == OpLw || op == OpSw) return 4'hF;
    if (op == OpLh || op == OpLhu || op == OpSh) return a[1] ? 4'hC : 4'h3;
    case (a[1:0])
      2'd0: return 4'h1;
      2'd1: return 4'h2;
      2'd2: return 4'h4;
      default: return 4'h8;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] d);
    if (op == OpSh) return {d[15:0], d[15:0]};
    if (op == OpSb) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = r[7:0];
      2'd1: b = r[15:8];
      2'd2: b = r[23:16];
      default: b = r[31:24];
    endcase
    h = a[1] ? r[31:16] : r[15:0];
    if (op == OpLb)  return {{24{b[7]}}, b};
    if (op == OpLbu) return {24'h0, b};
    if (op == OpLh)  return {{16{h[15]}}, h};
    if (op == OpLhu) return {16'h0, h};
    return r;
  endfunction

  // ack_at: REQ cycle (1-based) in which the ack is driven; 0 = never.
  task automatic run_access(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] din, input logic [31:0] rdata, input int ack_at);
    exp_t e, got;
    int   stall_n, req_n;
    logic done;
    logic mis;
    mis    = misal(op, addr);
    e.adel = mis && !is_st(op);
    e.ades = mis && is_st(op);
    e.err  = !mis && (ack_at == 0);
    if (mis || is_st(op)) e.d = model_d;
    else if (ack_at == 0) e.d = 32'h0;
    else e.d = exp_load(op, addr, rdata);
    e.reqs  = mis ? 0 : ((ack_at == 0) ? TO : ack_at);
    e.stall = mis ? 1 : 1 + e.reqs;
    model_d = e.d;
    sb.push_back(e);

    @(negedge Clk);
    MemAccess_In = 1'b1;
    Op_In        = op;
    Addr_In      = addr;
    D_In         = din;
    Bus_RData_In = rdata;
    Bus_Ack_In   = 1'b0;
    stall_n = 0;
    req_n   = 0;
    done    = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (i > 0) @(negedge Clk);
      #1;
      Bus_Ack_In = 1'b0;
      if (Bus_Req_Out) begin
        req_n++;
        check({tag, ".addr"}, Bus_Addr_Out, {addr[31:2], 2'b00});
        check({tag, ".be"}, {28'h0, Bus_Be_Out}, {28'h0, exp_be(op, addr)});
        check({tag, ".we"}, {31'h0, Bus_We_Out}, {31'h0, is_st(op)});
        if (is_st(op)) check({tag, ".wdata"}, Bus_WData_Out, exp_wdata(op, din));
        if (req_n == ack_at) Bus_Ack_In = 1'b1;
      end
      if (Stall_Out) stall_n++;
      else if (stall_n > 0) begin
        done = 1'b1;
        got  = sb.pop_front();
        check({tag, ".d"}, D_Out, got.d);
        check({tag, ".adel"}, {31'h0, AdEL_Out}, {31'h0, got.adel});
        check({tag, ".ades"}, {31'h0, AdES_Out}, {31'h0, got.ades});
        check({tag, ".err"}, {31'h0, Bus_Err_Out}, {31'h0, got.err});
        check({tag, ".stall"}, 32'(stall_n), 32'(got.stall));
        check({tag, ".reqs"}, 32'(req_n), 32'(got.reqs));
        MemAccess_In = 1'b0;
        Bus_Ack_In   = 1'b1;  // ack outside REQ must be ignored
      end
    end
    if (!done) begin
      total++;
      bad++;
      $error("FAIL %s.complete observed=no DONE expected=DONE within 200 cycles", tag);
      void'(sb.pop_front());
      MemAccess_In = 1'b0;
    end
    @(negedge Clk);
    #1;
    check({tag, ".after_req"}, {31'h0, Bus_Req_Out}, 32'h0);
    check({tag, ".after_flags"}, {29'h0, AdEL_Out, AdES_Out, Bus_Err_Out}, 32'h0);
    check({tag, ".after_d"}, D_Out, model_d);
    Bus_Ack_In = 1'b0;
  endtask

  initial begin
    Reset        = 1'b1;
    MemAccess_In = 1'b1;
    Op_In        = OpLw;
    Addr_In      = 32'h0;
    D_In         = 32'h0;
    Bus_Ack_In   = 1'b0;
    Bus_RData_In = 32'h0;
    repeat (2) @(negedge Clk);
    #1;
    check("rst.stall", {31'h0, Stall_Out}, 32'h0);
    check("rst.req", {31'h0, Bus_Req_Out}, 32'h0);
    check("rst.be", {28'h0, Bus_Be_Out}, 32'h0);
    check("rst.addr", Bus_Addr_Out, 32'h0);
    check("rst.wdata", Bus_WData_Out, 32'h0);
    check("rst.d", D_Out, 32'h0);
    MemAccess_In = 1'b0;
    Reset        = 1'b0;

    run_access("sw",  OpSw,  32'h10, 32'hDEADBEEF, 32'h0, 2);
    run_access("lb",  OpLb,  32'h13, 32'h0, 32'h80FF1234, 1);
    run_access("lbu", OpLbu, 32'h13, 32'h0, 32'h80FF1234, 1);
    run_access("sh",  OpSh,  32'h22, 32'h0000ABCD, 32'h0, 1);
    run_access("lhu", OpLhu, 32'h22, 32'h0, 32'hABCD0000, 1);
    run_access("lh",  OpLh,  32'h22, 32'h0, 32'hABCD0000, 1);
    run_access("lh_lo", OpLh, 32'h20, 32'h0, 32'h00008001, 3);
    run_access("sb",  OpSb,  32'h41, 32'h000000A5, 32'h0, 1);
    run_access("lw_mis", OpLw, 32'h6, 32'h0, 32'h0, 1);
    run_access("sh_mis", OpSh, 32'h5, 32'h0, 32'h0, 1);
    run_access("lw_to", OpLw, 32'h40, 32'h0, 32'h55555555, 0);
    run_access("lw", OpLw, 32'h44, 32'h0, 32'hCAFEF00D, 1);

    // Non-memory opcode: no stall, no request.
    @(negedge Clk);
    MemAccess_In = 1'b1;
    Op_In        = 6'b001000;
    #1;
    check("illegal.stall", {31'h0, Stall_Out}, 32'h0);
    @(negedge Clk);
    #1;
    check("illegal.req", {31'h0, Bus_Req_Out}, 32'h0);
    MemAccess_In = 1'b0;

    // Reset during the second REQ cycle of a store.
    @(negedge Clk);
    MemAccess_In = 1'b1;
    Op_In        = OpSw;
    Addr_In      = 32'h30;
    D_In         = 32'h11112222;
    #1;
    check("rmid.start_stall", {31'h0, Stall_Out}, 32'h1);
    @(negedge Clk);
    #1;
    check("rmid.req1", {31'h0, Bus_Req_Out}, 32'h1);
    @(negedge Clk);
    #1;
    check("rmid.req2", {31'h0, Bus_Req_Out}, 32'h1);
    Reset = 1'b1;
    #1;
    check("rmid.stall_forced", {31'h0, Stall_Out}, 32'h0);
    @(negedge Clk);
    #1;
    check("rmid.req", {31'h0, Bus_Req_Out}, 32'h0);
    check("rmid.we", {31'h0, Bus_We_Out}, 32'h0);
    check("rmid.addr", Bus_Addr_Out, 32'h0);
    check("rmid.d", D_Out, 32'h0);
    model_d      = 32'h0;
    Reset        = 1'b0;
    MemAccess_In = 1'b0;
    Bus_Ack_In   = 1'b1;
    @(negedge Clk);
    #1;
    check("rmid.late_ack", {31'h0, Bus_Req_Out}, 32'h0);
    check("rmid.idle_stall", {31'h0, Stall_Out}, 32'h0);
    Bus_Ack_In = 1'b0;
    run_access("lw_post", OpLw, 32'h8, 32'h0, 32'h12345678, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
MEM-stage load/store initiator that issues word-aligned requests to an external data-memory/bus responder over a req/ack handshake. Replaces the single-cycle memory access in the pipeline. Decodes MIPS load/store opcodes and generates byte enables and lane-replicated write data. Extracts and sign- or zero-extends load data, stalls the pipeline until the response arrives, and flags misalignment and bus timeout.

Parameters:
TIMEOUT_CYCLES, 64, max REQ-state cycles without Bus_Ack_In before a bus error; legal range 2..65535.

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
MemAccess_In  in  1  MEM-stage instruction is valid and is a memory op
Op_In  in  6  instruction opcode
Addr_In  in  32  effective byte address
D_In  in  32  store data (rt)
Stall_Out  out  1  freeze pipeline at or before MEM
D_Out  out  32  extended load result, valid in DONE, held until next completion
AdEL_Out  out  1  load address error, high in DONE only
AdES_Out  out  1  store address error, high in DONE only
Bus_Err_Out  out  1  timeout error, high in DONE only
Bus_Req_Out  out  1  request valid
Bus_We_Out  out  1  1 = write
Bus_Be_Out  out  4  byte enables; bit i = byte lane i, where lane i is bits [8i+7:8i]
Bus_Addr_Out  out  32  {addr[31:2],2'b00}
Bus_WData_Out  out  32  lane-replicated write data
Bus_Ack_In  in  1  responder accepted/completed; sampled only in REQ
Bus_RData_In  in  32  read word, valid with Bus_Ack_In

Behaviour:
- Opcodes:
  - Loads: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101.
  - Stores: sw 101011, sb 101000, sh 101001.
  - Any other opcode with MemAccess_In=1: no access, no stall, no flags.
- start = state==IDLE & MemAccess_In & legal opcode.
- Alignment faults:
  - lw/sw: Addr_In[1:0]!=0.
  - lh/lhu/sh: Addr_In[0]!=0.
  - Byte ops never fault.
- Byte enables:
  - word: 1111.
  - half: 0011 if addr[1]=0, 1100 if addr[1]=1.
  - byte: 0001<<addr[1:0].
  - Loads drive Be identically, for information only.
- Write data:
  - sw: D_In.
  - sh: {2{D_In[15:0]}}.
  - sb: {4{D_In[7:0]}}.
- Load extraction from the captured word:
  - lw: the whole word.
  - lb/lbu: lane addr[1:0].
  - lh/lhu: addr[1] ? [31:16] : [15:0].
  - lb/lh sign-extend; lbu/lhu zero-extend.
- FSM states IDLE, REQ, DONE:
  - IDLE, start & aligned: latch op, addr, Be, WData, We into registers; next state REQ; timeout counter cleared.
  - IDLE, start & misaligned: next state DONE with the AdEL/AdES flag set; no bus request ever issued.
  - REQ: Bus_Req_Out=1; all Bus_* outputs come from the latched registers and stay stable.
    - Bus_Ack_In=1: capture the extracted load into D_Out (stores leave D_Out unchanged); next state DONE.
    - No ack: counter increments; on reaching TIMEOUT_CYCLES-1 without ack, next state DONE with Bus_Err_Out set and D_Out=0.
  - DONE: exactly one cycle; flags high; inputs ignored (MEM still holds the same instruction); next state IDLE.
- Stall_Out = start | state==REQ (combinational); it is 0 in DONE so the pipeline advances at the end of DONE.
- Latency:
  - Ack in the first REQ cycle gives 3 cycles per access (IDLE, REQ, DONE), 2 of them stalled.
  - Each extra wait cycle adds 1.
- Bus_Req_Out is registered, derived from the next state; it is 0 in IDLE and DONE.
- Other outputs when not in REQ: Bus_We_Out=0; Bus_Be_Out, Bus_Addr_Out and Bus_WData_Out hold their last values.
- Bus_Ack_In outside REQ is ignored.
- Reset (takes priority, including mid-REQ):
  - Next edge: state IDLE, Bus_Req_Out 0, Bus_We_Out 0, Bus_Be_Out 0, Bus_Addr_Out 0, Bus_WData_Out 0.
  - D_Out 0, all flags 0, counter 0.
  - A pending transaction is abandoned and a late ack ignored.
  - While Reset is held, Stall_Out is forced to 0.
- Counter width: $clog2(TIMEOUT_CYCLES).

Test Plan:
1. sw Addr=0x0000_0010, D_In=0xDEADBEEF, ack after 2 REQ cycles -> Bus_We=1, Be=1111, Addr=0x10, WData=0xDEADBEEF; Stall high 3 cycles; DONE, no flags.
2. lb Addr=0x0000_0013, RData=0x80FF_1234, immediate ack -> D_Out=0xFFFF_FF80; the same access with lbu -> 0x0000_0080.
3. sh Addr=0x0000_0022, D_In=0x0000_ABCD -> Be=1100, WData=0xABCD_ABCD. Then lhu Addr=0x22, RData=0xABCD_0000 -> D_Out=0x0000_ABCD; lh with the same values -> 0xFFFF_ABCD.
4. lw Addr=0x0000_0006 -> no Bus_Req, AdEL_Out=1 for 1 cycle, Stall high 1 cycle; sh Addr=0x5 -> AdES_Out=1.
5. TIMEOUT_CYCLES=4, lw with ack never asserted -> Req high exactly 4 cycles, then Bus_Err_Out=1 one cycle, D_Out=0, then IDLE. A late ack is ignored.
6. Reset asserted on the 2nd REQ cycle of an sw -> next cycle Req=0, state IDLE, Stall=0. A subsequent lw with immediate ack completes normally in 3 cycles.
